// File: rtl/switches.sv
// Switch input peripheral: 2-flop sync, per-bit tick-based debounce, sticky change flags, level IRQ.
// Read data is combinational from registers; reads never stall and a flag read clears at the ending edge.
module switches #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 20000,
    parameter int DB_COUNT = 8
) (
    input  logic             sw_clk,
    input  logic             swrst,
    input  logic             swread,
    input  logic             swaddrcs,
    input  logic             swaddr,
    input  logic [WIDTH-1:0] swin,
    output logic [WIDTH-1:0] swrdata,
    output logic             swirq
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     CNT_LAST = 4'(DB_COUNT - 1);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] swsync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_nxt;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [3:0]       cnt     [WIDTH];
    logic [3:0]       cnt_nxt [WIDTH];

    always_ff @(posedge sw_clk or posedge swrst) begin
        if (swrst) begin
            sync_a <= '0;
            swsync <= '0;
        end else begin
            sync_a <= swin;
            swsync <= sync_a;
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge sw_clk or posedge swrst) begin
        if (swrst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // A bit's counter only advances while the synchronised level disagrees with the accepted one.
    always_comb begin
        deb_nxt  = deb;
        set_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (swsync[i] == deb[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_nxt[i]  = swsync[i];
                    cnt_nxt[i]  = '0;
                    set_mask[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge sw_clk or posedge swrst) begin
        if (swrst) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign clr_mask = {WIDTH{swread && swaddrcs && swaddr}};

    // Set is OR-ed in after the clear so a coincident acceptance is never lost.
    always_ff @(posedge sw_clk or posedge swrst) begin
        if (swrst) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        swrdata = '0;
        if (swaddrcs) begin
            swrdata = swaddr ? flags : deb;
        end
    end

    assign swirq = |flags;

endmodule
